pipe_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage core. It drives the per-stage hold vector that the pipeline registers (pc, if_id, id_ex, ex_mem, mem_wb) consume as active-high freeze, and a matching flush vector that makes a stage register load a NOP bubble. It arbitrates load-use, multi-cycle execute, data-memory wait and taken-jump events. A small state machine covers the two-cycle fetch shadow after a jump.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Holds stage bit indices, the hold/flush vectors per hazard class and the
// fetch-shadow state encoding.
package pipe_ctrl_pkg;

  localparam int unsigned NSTAGE = 5;

  // Stage bit positions in the hold/flush vectors
  localparam int unsigned HOLD_PC    = 0;
  localparam int unsigned HOLD_IF_ID = 1;
  localparam int unsigned HOLD_ID_EX = 2;
  localparam int unsigned HOLD_EX_MM = 3;
  localparam int unsigned HOLD_WB    = 4;

  localparam logic [NSTAGE-1:0] HOLD_NONE  = 5'b00000;
  localparam logic [NSTAGE-1:0] HOLD_MEM   = 5'b01111;
  localparam logic [NSTAGE-1:0] HOLD_EX    = 5'b00111;
  localparam logic [NSTAGE-1:0] HOLD_LD    = 5'b00011;

  localparam logic [NSTAGE-1:0] FLUSH_NONE = 5'b00000;
  localparam logic [NSTAGE-1:0] FLUSH_MEM  = 5'b10000;
  localparam logic [NSTAGE-1:0] FLUSH_EX   = 5'b01000;
  localparam logic [NSTAGE-1:0] FLUSH_JMP  = 5'b00110;
  localparam logic [NSTAGE-1:0] FLUSH_LD   = 5'b00100;
  localparam logic [NSTAGE-1:0] FLUSH_SHD  = 5'b00010;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FLUSH2 = 1'b1
  } state_e;

  // Per-cycle control decision towards the stage registers
  typedef struct packed {
    logic [NSTAGE-1:0] hold;
    logic [NSTAGE-1:0] flush;
    logic              jump;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller for the five-stage core.
// Ports:
//   clk, rstn          core clock, asynchronous active-low reset
//   id_ld_hazard_i     load-use hazard in id
//   ex_busy_i          multi-cycle ex op in progress (level)
//   ex_jump_i          taken branch/jump resolved in ex
//   ex_jump_addr_i     jump target
//   mem_busy_i         data memory not ready (level)
//   hold_en_o          per-stage freeze {wb, ex_mem, id_ex, if_id, pc}
//   flush_o            per-stage NOP load, same mapping
//   jump_flag_o        pc load strobe
//   jump_addr_o        pc load value
//   stall_cnt_o        held-cycle count     (PIPE_CTRL_PERF_EN only)
//   flush_cnt_o        jump/flush count     (PIPE_CTRL_PERF_EN only)
// Outputs are combinational so the stage registers react in the same cycle.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the two perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_ld_hazard_i,
  input  logic              ex_busy_i,
  input  logic              ex_jump_i,
  input  logic [AW-1:0]     ex_jump_addr_i,
  input  logic              mem_busy_i,
  output logic [NSTAGE-1:0] hold_en_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              jump_flag_o,
  output logic [AW-1:0]     jump_addr_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  state_e        state_q, state_d;
  ctrl_t         ctrl;
  logic [AW-1:0] jaddr;

  // Priority encoder: mem > ex > jump > load-use > fetch shadow
  always_comb begin
    ctrl    = '{hold: HOLD_NONE, flush: FLUSH_NONE, jump: 1'b0};
    jaddr   = '0;
    state_d = state_q;
    if (mem_busy_i) begin
      ctrl.hold  = HOLD_MEM;
      ctrl.flush = FLUSH_MEM;
    end else if (ex_busy_i) begin
      ctrl.hold  = HOLD_EX;
      ctrl.flush = FLUSH_EX;
    end else if (ex_jump_i) begin
      // A jump seen in FLUSH2 restarts the two-cycle shadow
      ctrl.flush = FLUSH_JMP;
      ctrl.jump  = 1'b1;
      jaddr      = ex_jump_addr_i;
      state_d    = ST_FLUSH2;
    end else if (id_ld_hazard_i) begin
      ctrl.hold  = HOLD_LD;
      ctrl.flush = FLUSH_LD;
      state_d    = ST_RUN;
    end else begin
      if (state_q == ST_FLUSH2) begin
        ctrl.flush = FLUSH_SHD;
      end
      state_d = ST_RUN;
    end
  end

  // Outputs forced quiet while reset is asserted
  assign hold_en_o   = rstn ? ctrl.hold  : HOLD_NONE;
  assign flush_o     = rstn ? ctrl.flush : FLUSH_NONE;
  assign jump_flag_o = rstn & ctrl.jump;
  assign jump_addr_o = rstn ? jaddr : '0;

  // Fetch-shadow state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters, wrapping at 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_en_o != HOLD_NONE) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (jump_flag_o) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand sequences
// for jump shadow and reset, then randomized traffic against a model.
module tb_pipe_ctrl;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          id_ld_hazard_i, ex_busy_i, ex_jump_i, mem_busy_i;
  logic [AW-1:0] ex_jump_addr_i;
  logic [4:0]    hold_en_o, flush_o;
  logic          jump_flag_o;
  logic [AW-1:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   stall_cnt_o, flush_cnt_o;
`endif

  pipe_ctrl #(.AW(AW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .id_ld_hazard_i (id_ld_hazard_i),
    .ex_busy_i      (ex_busy_i),
    .ex_jump_i      (ex_jump_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .mem_busy_i     (mem_busy_i),
    .hold_en_o      (hold_en_o),
    .flush_o        (flush_o),
    .jump_flag_o    (jump_flag_o),
    .jump_addr_o    (jump_addr_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: is a second wrong-path fetch still to be killed?
  bit          shadow_pending;
  int unsigned m_stalls, m_jumps;

  typedef struct {
    logic        mem, ex, jmp, ld;
    logic [31:0] addr;
    logic [4:0]  hold, flush;
    logic        jf;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic mem, logic ex, logic jmp, logic ld,
                              logic [31:0] addr, logic [4:0] hold,
                              logic [4:0] flush, logic jf);
    vec_t v;
    v.mem = mem; v.ex = ex; v.jmp = jmp; v.ld = ld; v.addr = addr;
    v.hold = hold; v.flush = flush; v.jf = jf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check before the next posedge, advance model.
  task automatic step(input logic rst_v, input logic mem, input logic ex,
                      input logic jmp, input logic ld, input logic [31:0] addr);
    logic [4:0]  e_hold, e_flush;
    logic        e_jf;
    logic [31:0] e_addr;
    bit          next_pending;
    @(negedge clk);
    rstn = rst_v; mem_busy_i = mem; ex_busy_i = ex; ex_jump_i = jmp;
    id_ld_hazard_i = ld; ex_jump_addr_i = addr;
    #1;
    e_hold = 5'b0; e_flush = 5'b0; e_jf = 1'b0; e_addr = 32'h0;
    next_pending = shadow_pending;
    if (!rst_v) begin
      shadow_pending = 1'b0;
      m_stalls = 0; m_jumps = 0;
      next_pending = 1'b0;
    end else if (mem) begin
      // memory wait: freeze all up to ex_mem, bubble into wb
      e_hold = 5'b01111; e_flush = 5'b10000;
    end else if (ex) begin
      e_hold = 5'b00111; e_flush = 5'b01000;
    end else if (jmp) begin
      e_flush = 5'b00110; e_jf = 1'b1; e_addr = addr;
      next_pending = 1'b1;
    end else if (ld) begin
      e_hold = 5'b00011; e_flush = 5'b00100;
      next_pending = 1'b0;
    end else begin
      if (shadow_pending) e_flush = 5'b00010;
      next_pending = 1'b0;
    end
    chk("hold_en", 32'(hold_en_o), 32'(e_hold));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("jump_flag", 32'(jump_flag_o), 32'(e_jf));
    chk("jump_addr", jump_addr_o, e_addr);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt_o, m_stalls);
    chk("flush_cnt", flush_cnt_o, m_jumps);
`endif
    if (rst_v) begin
      if (e_hold != 5'b0) m_stalls++;
      if (e_jf) m_jumps++;
    end
    shadow_pending = next_pending;
  endtask

  initial begin
    rstn = 1'b0; mem_busy_i = 0; ex_busy_i = 0; ex_jump_i = 0;
    id_ld_hazard_i = 0; ex_jump_addr_i = '0;
    shadow_pending = 0; m_stalls = 0; m_jumps = 0;

    //              mem ex jmp ld addr           hold      flush     jf
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0);
    tbl[1]  = mk(0, 0, 1, 0, 32'h0000_0080, 5'b00000, 5'b00110, 1);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00010, 0);
    tbl[3]  = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0);
    tbl[4]  = mk(0, 0, 0, 1, 32'h0,        5'b00011, 5'b00100, 0);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0);
    tbl[6]  = mk(0, 0, 1, 0, 32'h0000_0100, 5'b00000, 5'b00110, 1);
    tbl[7]  = mk(1, 0, 0, 0, 32'h0,        5'b01111, 5'b10000, 0);
    tbl[8]  = mk(1, 0, 0, 0, 32'h0,        5'b01111, 5'b10000, 0);
    tbl[9]  = mk(1, 0, 0, 0, 32'h0,        5'b01111, 5'b10000, 0);
    tbl[10] = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00010, 0);
    tbl[11] = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0);
    tbl[12] = mk(1, 1, 0, 1, 32'h0,        5'b01111, 5'b10000, 0);
    tbl[13] = mk(0, 1, 0, 1, 32'h0,        5'b00111, 5'b01000, 0);
    tbl[14] = mk(0, 0, 0, 1, 32'h0,        5'b00011, 5'b00100, 0);
    tbl[15] = mk(0, 0, 1, 0, 32'hDEAD_BEE0, 5'b00000, 5'b00110, 1);
    tbl[16] = mk(0, 0, 1, 0, 32'h1234_5678, 5'b00000, 5'b00110, 1);
    tbl[17] = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00010, 0);
    tbl[18] = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0);
    tbl[19] = mk(0, 1, 1, 0, 32'h0000_0040, 5'b00111, 5'b01000, 0);
    tbl[20] = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0);
    tbl[21] = mk(0, 0, 1, 0, 32'hFFFF_FFFC, 5'b00000, 5'b00110, 1);
    tbl[22] = mk(0, 0, 0, 1, 32'h0,        5'b00011, 5'b00100, 0);
    tbl[23] = mk(0, 0, 0, 0, 32'h0,        5'b00000, 5'b00000, 0);

    // Reset state, including inputs asserted during reset
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 1, 1, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 32'h0);

    // Directed table; also checks table expectations against the model-driven step
    for (int i = 0; i < 24; i++) begin
      step(1, tbl[i].mem, tbl[i].ex, tbl[i].jmp, tbl[i].ld, tbl[i].addr);
      chk("tbl_hold", 32'(hold_en_o), 32'(tbl[i].hold));
      chk("tbl_flush", 32'(flush_o), 32'(tbl[i].flush));
      chk("tbl_jf", 32'(jump_flag_o), 32'(tbl[i].jf));
      chk("tbl_addr", jump_addr_o, tbl[i].jf ? tbl[i].addr : 32'h0);
    end

    // Reset mid-FLUSH2 drops the pending shadow flush
    step(1, 0, 0, 1, 0, 32'h0000_0200);
    step(0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("rst_drop_flush", 32'(flush_o), 32'h0);

    // FLUSH2 survives an ex stall, then kills the second fetch
    step(1, 0, 0, 1, 0, 32'h0000_0300);
    step(1, 0, 1, 0, 0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("shadow_after_ex", 32'(flush_o), 32'h2);

`ifdef PIPE_CTRL_PERF_EN
    // Fresh count: 5 stall cycles plus 2 jumps
    step(0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(1, i[0], ~i[0], 0, 0, 32'h0);
    step(1, 0, 0, 1, 0, 32'h10);
    step(1, 0, 0, 1, 0, 32'h20);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("perf_stall5", stall_cnt_o, 32'd5);
    chk("perf_jump2", flush_cnt_o, 32'd2);
`endif

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
